// File: rtl/dac_update_sched_if.sv
// SPI write-master side of the DAC update scheduler: frame, strobe, ready and DAC sync routing.
// spi_wre_o is a one-cycle strobe that qualifies spi_data_o; the master accepts by dropping spi_rdy_i, completes by raising it.
interface dac_update_sched_if #(
  parameter int NUM_CH  = 4,
  parameter int FRAME_W = 16
);
  logic [FRAME_W-1:0] spi_data_o;
  logic               spi_wre_o;
  logic               spi_rdy_i;
  logic [NUM_CH-1:0]  cs_sel_o;

  modport master (
    output spi_data_o,
    output spi_wre_o,
    output cs_sel_o,
    input  spi_rdy_i
  );

  modport slave (
    input  spi_data_o,
    input  spi_wre_o,
    input  cs_sel_o,
    output spi_rdy_i
  );
endinterface

// File: rtl/dac_update_sched.sv
// Round-robin scheduler sharing one SPI write master among NUM_CH DAC channels,
// with per-channel pending bits, periodic refresh and a re-strobe on a stuck master.
module dac_update_sched #(
  parameter int NUM_CH  = 4,
  parameter int FRAME_W = 16,
  parameter int DAC_W   = 8
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic [NUM_CH-1:0]       ch_req_i,
  input  logic [NUM_CH*DAC_W-1:0] ch_code_i,
  input  logic [NUM_CH*2-1:0]     ch_pd_i,
  output logic [NUM_CH-1:0]       ch_ack_o,
  input  logic [15:0]             refresh_period_i,
  output logic                    busy_o,
  output logic [2:0]              state_o,
  dac_update_sched_if.master      spi
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    ISSUE      = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  pending_q, set_vec, clr_vec;
  logic [GW-1:0]      last_grant_q, grant_q, pick;
  logic [NUM_CH-1:0]  pick_oh, cs_sel_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [1:0]         wait_cnt_q;
  logic               rereq_q;
  logic [15:0]        refresh_cnt_q;
  logic               refresh_tick;
  logic               done;
  logic               found;
  int                 pick_idx;

  assign refresh_tick = (refresh_period_i != 16'd0) &&
                        (refresh_cnt_q >= refresh_period_i - 16'd1);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                                          refresh_cnt_q <= '0;
    else if (refresh_period_i == 16'd0 || refresh_tick)  refresh_cnt_q <= '0;
    else                                                 refresh_cnt_q <= refresh_cnt_q + 16'd1;
  end

  assign set_vec = ch_req_i | {NUM_CH{refresh_tick}};
  assign done    = (state_q == WAIT_DONE) && spi.spi_rdy_i;

  // A request that lands while its channel is in flight keeps pending set so it is re-sent.
  always_comb begin
    clr_vec = '0;
    if (done && !rereq_q) clr_vec[grant_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) pending_q <= '0;
    else        pending_q <= (pending_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    pick     = last_grant_q;
    found    = 1'b0;
    pick_idx = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      pick_idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!found && pending_q[pick_idx]) begin
        pick  = GW'(pick_idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    frame_d                     = '0;
    frame_d[FRAME_W-3 -: 2]     = ch_pd_i[pick*2 +: 2];
    frame_d[FRAME_W-5 -: DAC_W] = ch_code_i[pick*DAC_W +: DAC_W];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (|pending_q && spi.spi_rdy_i) state_d = LOAD;
      LOAD:       state_d = ISSUE;
      ISSUE:      state_d = WAIT_START;
      WAIT_START: begin
        if (!spi.spi_rdy_i)          state_d = WAIT_DONE;
        else if (wait_cnt_q == 2'd3) state_d = ISSUE;
      end
      WAIT_DONE:  if (spi.spi_rdy_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      frame_q      <= '0;
      cs_sel_q     <= '0;
      wait_cnt_q   <= '0;
      rereq_q      <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        grant_q  <= pick;
        frame_q  <= frame_d;
        cs_sel_q <= pick_oh;
        rereq_q  <= set_vec[pick];
      end else if (state_q != IDLE && set_vec[grant_q]) begin
        rereq_q <= 1'b1;
      end
      if (state_q == ISSUE)           wait_cnt_q <= '0;
      else if (state_q == WAIT_START) wait_cnt_q <= wait_cnt_q + 2'd1;
      if (done) begin
        last_grant_q <= grant_q;
        cs_sel_q     <= '0;
      end
    end
  end

  always_comb begin
    ch_ack_o = '0;
    if (done) ch_ack_o[grant_q] = 1'b1;
  end

  // Select is shown during LOAD already; pick is stable there because pending only moves on edges.
  assign spi.cs_sel_o   = (state_q == LOAD) ? pick_oh : cs_sel_q;
  assign spi.spi_wre_o  = (state_q == ISSUE);
  assign spi.spi_data_o = frame_q;
  assign busy_o         = (state_q != IDLE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_dac_update_sched.sv
// Directed bench for dac_update_sched: the bench plays the SPI master by hand and checks
// frames, selects, acks, re-strobes, reset abandonment and refresh timing.
module tb_dac_update_sched;

  logic        clk = 1'b0;
  logic        arst;
  logic [3:0]  ch_req;
  logic [31:0] ch_code;
  logic [7:0]  ch_pd;
  logic [3:0]  ch_ack;
  logic [15:0] period;
  logic        busy;
  logic [2:0]  state;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          c0, t_first;

  dac_update_sched_if #(.NUM_CH(4), .FRAME_W(16)) spi_if ();

  dac_update_sched #(.NUM_CH(4), .FRAME_W(16), .DAC_W(8)) dut (
    .clk_i            (clk),
    .arst_i           (arst),
    .ch_req_i         (ch_req),
    .ch_code_i        (ch_code),
    .ch_pd_i          (ch_pd),
    .ch_ack_o         (ch_ack),
    .refresh_period_i (period),
    .busy_o           (busy),
    .state_o          (state),
    .spi              (spi_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    checks++;
    assert ($onehot0(spi_if.cs_sel_o) === 1'b1) else begin
      errors++;
      $error("FAIL cs_onehot observed=%b required=onehot0", spi_if.cs_sel_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] code, input logic [1:0] pd);
    ch_code[ch*8 +: 8] = code;
    ch_pd[ch*2 +: 2]   = pd;
  endtask

  task automatic wait_wre(input int ch, input logic [15:0] exp_data, input string tag);
    int n = 0;
    while (spi_if.spi_wre_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_wre"}, spi_if.spi_wre_o, 32'd1);
    chk({tag, "_data"}, spi_if.spi_data_o, exp_data);
    chk({tag, "_cs"}, spi_if.cs_sel_o, 32'd1 << ch);
  endtask

  task automatic finish_frame(input int ch, input logic [15:0] exp_data, input bit rereq,
                              input string tag);
    spi_if.spi_rdy_i = 1'b0;
    step();
    chk({tag, "_wre_once"}, spi_if.spi_wre_o, 32'd0);
    step();
    chk({tag, "_wait_done"}, state, 32'd4);
    if (rereq) begin
      set_ch(2, 8'h3C, 2'b00);
      ch_req[2] = 1'b1;
      step();
      ch_req = '0;
    end
    step();
    chk({tag, "_no_early_ack"}, ch_ack, 32'd0);
    spi_if.spi_rdy_i = 1'b1;
    #1;
    chk({tag, "_ack"}, ch_ack, 32'd1 << ch);
    chk({tag, "_cs_hold"}, spi_if.cs_sel_o, 32'd1 << ch);
    chk({tag, "_data_hold"}, spi_if.spi_data_o, exp_data);
    step();
    chk({tag, "_ack_clr"}, ch_ack, 32'd0);
    chk({tag, "_cs_clr"}, spi_if.cs_sel_o, 32'd0);
  endtask

  task automatic idle_window(input int cycles, input string tag);
    int w = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (spi_if.spi_wre_o === 1'b1 || ch_ack !== 4'd0 || busy !== 1'b0) w++;
    end
    chk({tag, "_quiet"}, w, 32'd0);
  endtask

  task automatic reset_dut();
    arst = 1'b1;
    step();
    arst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp2 [4];
    logic [15:0] exp6 [4];
    exp2 = '{16'h1110, 16'h2220, 16'h3330, 16'h0440};
    exp6 = '{16'h2120, 16'h1340, 16'h3560, 16'h0780};
    arst = 1'b1;
    ch_req = '0;
    ch_code = '0;
    ch_pd = '0;
    period = '0;
    spi_if.spi_rdy_i = 1'b1;
    step();
    step();

    chk("rst_state", state, 32'd0);
    chk("rst_wre", spi_if.spi_wre_o, 32'd0);
    chk("rst_data", spi_if.spi_data_o, 32'd0);
    chk("rst_cs", spi_if.cs_sel_o, 32'd0);
    chk("rst_ack", ch_ack, 32'd0);
    chk("rst_busy", busy, 32'd0);
    arst = 1'b0;
    step();

    // single request on channel 0
    set_ch(0, 8'hA5, 2'b00);
    ch_req = 4'b0001;
    step();
    ch_req = '0;
    chk("t1_idle", state, 32'd0);
    step();
    chk("t1_load", state, 32'd1);
    chk("t1_load_cs", spi_if.cs_sel_o, 32'd1);
    chk("t1_load_busy", busy, 32'd1);
    step();
    wait_wre(0, 16'h0A50, "t1");
    finish_frame(0, 16'h0A50, 1'b0, "t1");
    idle_window(6, "t1");

    // all four at once from reset
    reset_dut();
    set_ch(0, 8'h11, 2'b01);
    set_ch(1, 8'h22, 2'b10);
    set_ch(2, 8'h33, 2'b11);
    set_ch(3, 8'h44, 2'b00);
    ch_req = 4'b1111;
    step();
    ch_req = '0;
    for (int k = 0; k < 4; k++) begin
      wait_wre(k, exp2[k], $sformatf("t2_ch%0d", k));
      finish_frame(k, exp2[k], 1'b0, $sformatf("t2_ch%0d", k));
    end
    idle_window(8, "t2");

    // re-request of channel 2 while in flight
    set_ch(2, 8'h5A, 2'b00);
    ch_req = 4'b0100;
    step();
    ch_req = '0;
    wait_wre(2, 16'h05A0, "t3a");
    finish_frame(2, 16'h05A0, 1'b1, "t3a");
    wait_wre(2, 16'h03C0, "t3b");
    finish_frame(2, 16'h03C0, 1'b0, "t3b");
    idle_window(8, "t3");

    // master never leaves ready: strobe repeats every 5 cycles, no ack
    set_ch(1, 8'h80, 2'b00);
    ch_req = 4'b0010;
    step();
    ch_req = '0;
    wait_wre(1, 16'h0800, "t4");
    for (int r = 0; r < 2; r++) begin
      int extra = 0;
      for (int i = 1; i < 5; i++) begin
        step();
        if (spi_if.spi_wre_o === 1'b1 || ch_ack !== 4'd0) extra++;
      end
      chk("t4_gap_quiet", extra, 32'd0);
      step();
      chk("t4_restrobe", spi_if.spi_wre_o, 32'd1);
      chk("t4_restrobe_data", spi_if.spi_data_o, 32'h0800);
    end
    chk("t4_cs", spi_if.cs_sel_o, 32'd2);
    finish_frame(1, 16'h0800, 1'b0, "t4");

    // reset in WAIT_DONE abandons the frame
    set_ch(3, 8'h77, 2'b01);
    ch_req = 4'b1000;
    step();
    ch_req = '0;
    wait_wre(3, 16'h1770, "t5");
    spi_if.spi_rdy_i = 1'b0;
    step();
    step();
    chk("t5_wait_done", state, 32'd4);
    chk("t5_cs_before", spi_if.cs_sel_o, 32'd8);
    arst = 1'b1;
    #1;
    chk("t5_cs", spi_if.cs_sel_o, 32'd0);
    chk("t5_wre", spi_if.spi_wre_o, 32'd0);
    chk("t5_data", spi_if.spi_data_o, 32'd0);
    chk("t5_ack", ch_ack, 32'd0);
    chk("t5_busy", busy, 32'd0);
    chk("t5_state", state, 32'd0);
    step();
    arst = 1'b0;
    spi_if.spi_rdy_i = 1'b1;
    idle_window(10, "t5");

    // refresh every 100 cycles, then disabled
    set_ch(0, 8'h12, 2'b10);
    set_ch(1, 8'h34, 2'b01);
    set_ch(2, 8'h56, 2'b11);
    set_ch(3, 8'h78, 2'b00);
    arst = 1'b1;
    period = 16'd100;
    step();
    arst = 1'b0;
    c0 = cyc;
    wait_wre(0, exp6[0], "t6r1_ch0");
    chk("t6_first_latency", cyc - c0, 32'd102);
    t_first = cyc;
    finish_frame(0, exp6[0], 1'b0, "t6r1_ch0");
    for (int k = 1; k < 4; k++) begin
      wait_wre(k, exp6[k], $sformatf("t6r1_ch%0d", k));
      finish_frame(k, exp6[k], 1'b0, $sformatf("t6r1_ch%0d", k));
    end
    set_ch(1, 8'hFF, 2'b00);
    exp6[1] = 16'h0FF0;
    wait_wre(0, exp6[0], "t6r2_ch0");
    chk("t6_period", cyc - t_first, 32'd100);
    finish_frame(0, exp6[0], 1'b0, "t6r2_ch0");
    for (int k = 1; k < 4; k++) begin
      wait_wre(k, exp6[k], $sformatf("t6r2_ch%0d", k));
      finish_frame(k, exp6[k], 1'b0, $sformatf("t6r2_ch%0d", k));
    end
    period = 16'd0;
    idle_window(250, "t6_off");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_update_sched.md
DAC_UPDATE_SCHED -- requirements
Module: dac_update_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of DAC channels sharing one SPI write master.
REQ-002 SHALL have parameter FRAME_W, default 16, meaning SPI frame width presented to the SPI master.
REQ-003 SHALL have parameter DAC_W, default 8, meaning DAC code width per channel.
REQ-004 SHALL have port clk_i, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port arst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port ch_req_i, input, NUM_CH, per-channel one-cycle update request.
REQ-007 SHALL have port ch_code_i, input, NUM_CH*DAC_W, per-channel DAC code; channel i at slice [i*DAC_W +: DAC_W].
REQ-008 SHALL have port ch_pd_i, input, NUM_CH*2, per-channel power-down mode bits.
REQ-009 SHALL have port ch_ack_o, output, NUM_CH, one-cycle pulse when that channel's frame has completed.
REQ-010 SHALL have port refresh_period_i, input, 16, cycles between automatic refreshes of all channels; 0 disables refresh.
REQ-011 SHALL have port spi_data_o, output, FRAME_W, frame to the SPI master.
REQ-012 SHALL have port spi_wre_o, output, 1, write strobe to the SPI master.
REQ-013 SHALL have port spi_rdy_i, input, 1, SPI master ready; high means idle.
REQ-014 SHALL have port cs_sel_o, output, NUM_CH, one-hot select routing the SPI sync line to the granted DAC; all-zero when idle.
REQ-015 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL keep a pending bit per channel; ch_req_i[i] or a refresh tick sets pending[i].
REQ-017 SHALL clear pending[i] only on completion of channel i's frame; a set in the same cycle as a clear SHALL win.
REQ-018 SHALL implement states IDLE, LOAD, ISSUE, WAIT_START and WAIT_DONE.
REQ-019 IDLE -> LOAD when any pending bit is set and spi_rdy_i=1; otherwise stay in IDLE.
REQ-020 LOAD: pick a channel round-robin, searching from last_grant+1 modulo NUM_CH.
REQ-021 LOAD: capture ch_code_i and ch_pd_i for the granted channel into the frame register.
REQ-022 LOAD: drive cs_sel_o one-hot for the granted channel, then -> ISSUE.
REQ-023 Frame format SHALL be: bits[15:14]=00, [13:12]=pd, [11:4]=code, [3:0]=0000; data is sampled at LOAD, not at request time.
REQ-024 ISSUE: spi_wre_o=1 for exactly one cycle with spi_data_o valid, then -> WAIT_START.
REQ-025 WAIT_START: wait for spi_rdy_i=0, then -> WAIT_DONE.
REQ-026 WAIT_START timeout: if spi_rdy_i is still 1 after 4 cycles, -> ISSUE again (re-strobe).
REQ-027 WAIT_DONE: on spi_rdy_i=1, pulse ch_ack_o[grant] for one cycle, clear pending[grant], update last_grant, clear cs_sel_o and -> IDLE.
REQ-028 cs_sel_o SHALL stay stable from LOAD through the WAIT_DONE exit cycle.
REQ-029 spi_data_o SHALL stay stable from ISSUE through the WAIT_DONE exit cycle.
REQ-030 A request on the channel in flight SHALL leave pending set, so the channel is re-sent with the then-current code.
REQ-031 Refresh counter: 16-bit; increments every cycle while refresh_period_i!=0.
REQ-032 Refresh counter: on reaching refresh_period_i-1, emits a tick setting all pending bits, then wraps to 0.
REQ-033 Refresh counter: held at 0 while refresh_period_i=0.
REQ-034 Worst-case service latency SHALL be NUM_CH frames after the request.
REQ-035 Minimum gap between frames SHALL be 2 cycles (IDLE, LOAD).

Reset
REQ-036 On arst_i, SHALL drive: state=IDLE, pending=0, last_grant=NUM_CH-1, refresh counter=0.
REQ-037 On arst_i, SHALL drive outputs: spi_wre_o=0, spi_data_o=0, cs_sel_o=0, ch_ack_o=0, busy_o=0.
REQ-038 Reset mid-frame SHALL abandon the frame with no ack; cs_sel_o is deasserted immediately.

Verification
REQ-039 Single request: ch_req_i=0001, code0=0xA5, pd0=00 -> spi_data_o=0x0A50, one wre pulse, cs_sel_o=0001, ch_ack_o[0] pulse after rdy returns high.
REQ-040 Simultaneous requests: ch_req_i=1111 from reset -> service order 0,1,2,3, four acks, cs_sel_o never multi-hot.
REQ-041 Re-request in flight: pulse ch_req_i[2] during WAIT_DONE of ch2 with the code changed to 0x3C -> ch2 is sent again with frame 0x03C0.
REQ-042 Refresh: refresh_period_i=100 with no requests -> all 4 channels rewritten every 100 cycles; period=0 -> no frames.
REQ-043 Stuck master: spi_rdy_i held high after wre -> wre re-issued every 5 cycles, no ack.
REQ-044 Reset mid-frame: assert arst_i in WAIT_DONE -> all outputs 0 same cycle, no ack, pending cleared.
